// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: round-robin I/D arbiter onto one memory port,
// one outstanding transaction, watchdog turns a hung response into err.
// Ports: clk, reset (sync, high)
//   i_*   fetch: req/addr in; gnt/rvalid/rdata/err out
//   d_*   load/store: req/op/addr/wdata/be in; gnt/rvalid/rdata/err out
//   mem_* downstream: req/we/addr/wdata/be out; gnt/rvalid/rdata in
module rv32i_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic MEM_STORE = 1'b1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e r_state;
  state_e w_next;

  logic             r_last_d;
  logic             r_owner_d;
  logic [CNT_W-1:0] r_cnt;

  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_be;

  logic             r_i_rvalid;
  logic [31:0]      r_i_rdata;
  logic             r_i_err;
  logic             r_d_rvalid;
  logic [31:0]      r_d_rdata;
  logic             r_d_err;

  logic w_pick_i;
  logic w_pick_d;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_done;
  logic w_tout;
  logic w_to_hit;
  logic w_resp;

  // On a tie the port that did not win last time goes first.
  assign w_pick_i = i_req & ~reset & (~d_req | r_last_d);
  assign w_pick_d = d_req & ~reset & (~i_req | ~r_last_d);

  assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_CNT);
  assign w_resp   = w_done | w_tout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    w_done  = 1'b0;
    w_tout  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_gnt_i = w_pick_i;
        w_gnt_d = w_pick_d;
        if (w_pick_i | w_pick_d) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_to_hit) begin
          w_tout = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d    <= 1'b1;
      r_owner_d   <= 1'b0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_i_rvalid  <= 1'b0;
      r_i_rdata   <= '0;
      r_i_err     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;

      if (w_gnt_i | w_gnt_d) begin
        r_mem_req <= 1'b1;
        r_owner_d <= w_gnt_d;
        r_last_d  <= w_gnt_d;
        if (w_gnt_d) begin
          r_mem_we    <= (d_op == MEM_STORE);
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
          r_mem_be    <= d_be;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= i_addr;
          r_mem_wdata <= '0;
          r_mem_be    <= 4'b1111;
        end
      end

      if (r_state == S_ISSUE && mem_gnt) begin
        r_mem_req <= 1'b0;
        r_cnt     <= '0;
      end else if (r_state == S_WAIT && !w_resp) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A timeout returns zero data with err set.
      if (w_resp) begin
        if (r_owner_d) begin
          r_d_rvalid <= 1'b1;
          r_d_err    <= w_tout;
          r_d_rdata  <= w_done ? mem_rdata : 32'h0;
        end else begin
          r_i_rvalid <= 1'b1;
          r_i_err    <= w_tout;
          r_i_rdata  <= w_done ? mem_rdata : 32'h0;
        end
      end
    end
  end

  assign i_gnt     = w_gnt_i;
  assign d_gnt     = w_gnt_d;
  assign i_rvalid  = r_i_rvalid;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Two-requester memory port arbiter for the RV32I core. It shares a single downstream memory port between instruction fetch (I port, read-only) and the load/store unit (D port, `mem_op_e` load/store with byte enables). It grants round-robin, sequences one outstanding transaction at a time through a request/accept/response protocol, and routes the response back to the owner. A watchdog converts a hung memory response into an error response.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles in WAIT before an error response is forced. 0 disables the watchdog.
- `CNT_W`, default 8: width of the watchdog counter. `TIMEOUT` must fit in it.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request. Held with `i_addr` stable until `i_gnt`.
- `i_addr` in 32: fetch address.
- `i_gnt` out 1: one-cycle pulse. The fetch request is accepted.
- `i_rvalid` out 1: one-cycle pulse. Fetch response is valid.
- `i_rdata` out 32: fetch data. Valid with `i_rvalid`.
- `i_err` out 1: fetch timed out. Qualified by `i_rvalid`.
- `d_req` in 1: data request. Held with its fields stable until `d_gnt`.
- `d_op` in 1 (`mem_op_e`): `MEM_LOAD` or `MEM_STORE`.
- `d_addr` in 32, `d_wdata` in 32, `d_be` in 4: data request fields.
- `d_gnt` out 1, `d_rvalid` out 1, `d_rdata` out 32, `d_err` out 1: same semantics as the I port. A store also receives `d_rvalid` as its write-complete indication.
- `mem_req` out 1: downstream request. Held until `mem_gnt`.
- `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_be` out 4: downstream fields. Registered and stable while `mem_req` is high.
- `mem_gnt` in 1: downstream accepted the request.
- `mem_rvalid` in 1: downstream response. Issued for both reads and writes.
- `mem_rdata` in 32: downstream read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE.
- **IDLE**
  - Arbitrate only if `i_req` or `d_req` is high.
  - If exactly one requester is active, it wins.
  - If both are active, the winner is the port not recorded in `last_grant`.
  - `last_grant` resets to D, so the first tie after reset goes to I.
  - The winner's `x_gnt` is asserted combinationally in IDLE.
  - On that edge: latch the winner's fields into the `mem_*` registers, record `owner` and `last_grant`, and go to ISSUE.
- **Field mapping**
  - I port: `mem_we`=0, `mem_be`=4'b1111, `mem_wdata`=0.
  - D port: `mem_we`=(`d_op`==`MEM_STORE`), with `d_be` and `d_wdata` passed through.
- **ISSUE**: `mem_req`=1. When `mem_gnt` is sampled high, deassert `mem_req`, clear the watchdog counter, and go to WAIT.
- **WAIT**
  - On `mem_rvalid`: register `mem_rdata` into `owner`'s rdata, set `owner`'s rvalid for the next cycle with err=0, and go to IDLE.
  - Otherwise the counter increments.
  - When the counter equals `TIMEOUT` (and `TIMEOUT`≠0): set `owner`'s rvalid and err for the next cycle with rdata=0, and go to IDLE.
- **Ignored inputs**
  - `mem_rvalid` is ignored outside WAIT.
  - A response that arrives after a timeout is a downstream protocol violation and is not handled.
  - `mem_gnt` is ignored outside ISSUE.
- **Response outputs**
  - `x_rdata` holds its last value until the next response to that port.
  - The rvalid of the non-owner port is never asserted.
- **Reset**
  - Reset mid-transaction aborts the transaction.
  - The next cycle shows all outputs at reset values and the FSM in IDLE.
  - Any pending downstream response is dropped.

## Timing
- **Reset values**: `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `i_err`, `d_err`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0; `mem_be` = 0.
- **Minimum latency**:
  - Cycle N: `req` is high and `gnt` pulses.
  - Cycle N+1: `mem_req` is high and `mem_gnt` is high.
  - Cycle N+2: WAIT, `mem_rvalid` arrives.
  - Cycle N+3: `x_rvalid` is high.
- **Back-to-back issue**: the FSM is in IDLE during the `x_rvalid` cycle, so a new grant may coincide with `x_rvalid`. Sustained throughput is one transaction per 3 cycles plus memory latency.
- **Grant timing**: `gnt` is only ever asserted in IDLE and to at most one port per cycle.
- **Request deassertion**: a requester that drops `req` before `gnt` is simply not granted; there is no penalty.
- **Watchdog**: an error response appears `TIMEOUT`+1 cycles after the WAIT entry edge.

## Test plan
- **Single fetch**: `i_req`, `i_addr`=0x100; memory gnt in 1 cycle, rvalid 1 cycle later with 0xDEADBEEF → `i_gnt` at N, `mem_req`/`mem_addr`=0x100/`mem_we`=0 at N+1, `i_rvalid`/`i_rdata`=0xDEADBEEF at N+3, `d_rvalid` never asserted.
- **Simultaneous requests after reset**, both held → grant order I, D, I, D, with one response per grant routed correctly; a store with `d_be`=4'b0011 drives `mem_we`=1 and `mem_be`=4'b0011.
- **Back-pressure**: `mem_gnt` low for 5 cycles → `mem_req` and fields stable throughout; no new `gnt` issued to either port until the response.
- **Timeout**: `TIMEOUT`=4, memory never sends rvalid → `d_rvalid`=1, `d_err`=1, `d_rdata`=0 at exactly 5 cycles after the WAIT entry edge; the next request is served normally.
- **Reset in WAIT**: assert `reset` for 1 cycle → all outputs are 0 next cycle; a subsequent late `mem_rvalid` produces no `x_rvalid`.
- **Grant/response overlap**: `d_req` asserted in the same cycle as `i_rvalid` → `d_gnt` in that cycle.
